// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the frame state encoding
// used by both the transmitter and receiver FSMs.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit tick counter: runs 0..OVERSAMPLE-1 and flags the last tick of each bit.
// Held at zero while i_clear is high so each frame starts on a fresh bit boundary.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] r_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick <= '0;
        end else if (i_clear || (r_tick == LAST_TICK)) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    assign o_bit_done = (r_tick == LAST_TICK);

endmodule

// File: rtl/uart_tx.sv
// RS-232 transmitter: start, DATA_BITS data bits LSB first, optional even parity
// (UART_TX_PARITY_EN), STOP_BITS stop bits; 16 CLK_x16 cycles per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 CLK_x16,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TXD,
    output logic                 BUSY
);

    localparam int unsigned        BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_txd;
    logic                   w_txd_next;
    logic                   w_bit_done;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_bit_inc;
    logic                   w_stop_inc;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    assign TX_READY = (r_state == IDLE) && !RST;
    assign BUSY     = (r_state != IDLE);
    assign TXD      = r_txd;
    assign w_accept = TX_VALID && TX_READY;

    uart_bit_timer u_bit_timer (
        .i_clk      (CLK_x16),
        .i_rst      (RST),
        .i_clear    (r_state == IDLE),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge CLK_x16 or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_txd   <= w_txd_next;
        end
    end

    // TXD is registered, so each branch chooses the level for the next bit slot.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = r_txd;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_bit_inc    = 1'b0;
        w_stop_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                w_txd_next = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                    w_txd_next   = 1'b0;
                    w_load       = 1'b1;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_txd_next   = r_shift[0];
                    w_shift      = 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_txd_next   = r_parity;
`else
                        w_state_next = STOP;
                        w_txd_next   = 1'b1;
`endif
                    end else begin
                        w_txd_next = r_shift[0];
                        w_shift    = 1'b1;
                        w_bit_inc  = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                    w_txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                w_txd_next = 1'b1;
                if (w_bit_done) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state_next = IDLE;
                    end else begin
                        w_stop_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_x16 or posedge RST) begin
        if (RST) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else if (w_load) begin
            r_shift    <= TX_DATA;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            if (w_shift) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_stop_inc) begin
                r_stop_cnt <= 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK_x16 or posedge RST) begin
        if (RST) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^TX_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default 8N1 instance plus a 7-bit, 2-stop instance.
// Frame slot patterns are given as {stop(s), [parity,] data, start} constants.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data8;
    logic       valid8;
    logic       ready8;
    logic       txd8;
    logic       busy8;
    logic [6:0] data7;
    logic       valid7;
    logic       ready7;
    logic       txd7;
    logic       busy7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx u_dut8 (
        .CLK_x16  (clk),
        .RST      (rst),
        .TX_DATA  (data8),
        .TX_VALID (valid8),
        .TX_READY (ready8),
        .TXD      (txd8),
        .BUSY     (busy8)
    );

    uart_tx #(
        .DATA_BITS (7),
        .STOP_BITS (2)
    ) u_dut7 (
        .CLK_x16  (clk),
        .RST      (rst),
        .TX_DATA  (data7),
        .TX_VALID (valid7),
        .TX_READY (ready7),
        .TXD      (txd7),
        .BUSY     (busy7)
    );

    // Called #1 after the handshake edge; walks the frame cycle by cycle up to
    // the edge where TX_READY must return.
    task automatic check_frame(input string name, input bit sel,
                               input logic [15:0] slots, input int nslots);
        int   flen;
        logic exp_txd;
        logic exp_rdy;
        logic obs_txd;
        logic obs_rdy;
        logic obs_busy;
        flen = 16 * nslots;
        for (int k = 0; k <= flen; k++) begin
            exp_txd  = (k == flen) ? 1'b1 : slots[k / 16];
            exp_rdy  = (k == flen);
            obs_txd  = sel ? txd7 : txd8;
            obs_rdy  = sel ? ready7 : ready8;
            obs_busy = sel ? busy7 : busy8;
            checks++;
            if (obs_txd !== exp_txd) begin
                errors++;
                $display("FAIL %s txd cycle %0d: got %b expected %b", name, k, obs_txd, exp_txd);
            end
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL %s ready cycle %0d: got %b expected %b", name, k, obs_rdy, exp_rdy);
            end
            checks++;
            if (obs_busy !== !exp_rdy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, obs_busy, !exp_rdy);
            end
            if (k < flen) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send8(input logic [7:0] d);
        data8  = d;
        valid8 = 1'b1;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        data8  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd: got %b expected 1", txd8);
        end
        checks++;
        if (ready8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0", ready8);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy8);
        end
        checks++;
        if (txd7 !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd7: got %b expected 1", txd7);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready8 !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b expected 1", ready8);
        end
        checks++;
        if (txd8 !== 1'b1) begin
            errors++;
            $display("FAIL release_txd: got %b expected 1", txd8);
        end
        checks++;
        if (ready7 !== 1'b1) begin
            errors++;
            $display("FAIL release_ready7: got %b expected 1", ready7);
        end
    endtask

    task automatic test_single();
        send8(8'hA5);
`ifdef UART_TX_PARITY_EN
        check_frame("single_a5", 1'b0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11);
`else
        check_frame("single_a5", 1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        data8  = 8'h00;
        valid8 = 1'b1;
        @(posedge clk);
        #1;
        data8 = 8'hFF;
`ifdef UART_TX_PARITY_EN
        check_frame("b2b_00", 1'b0, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 11);
`else
        check_frame("b2b_00", 1'b0, 16'({1'b1, 8'h00, 1'b0}), 10);
`endif
        @(posedge clk);
        #1;
        valid8 = 1'b0;
`ifdef UART_TX_PARITY_EN
        check_frame("b2b_ff", 1'b0, 16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11);
`else
        check_frame("b2b_ff", 1'b0, 16'({1'b1, 8'hFF, 1'b0}), 10);
`endif
        @(posedge clk);
        #1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        send8(8'h07);
        check_frame("parity_07", 1'b0, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        @(posedge clk);
        #1;
        send8(8'h03);
        check_frame("parity_03", 1'b0, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_reset_midframe();
        send8(8'h00);
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (txd8 !== 1'b0) begin
            errors++;
            $display("FAIL midframe_txd_before: got %b expected 0", txd8);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (txd8 !== 1'b1) begin
            errors++;
            $display("FAIL midframe_txd_async: got %b expected 1", txd8);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL midframe_busy: got %b expected 0", busy8);
        end
        checks++;
        if (ready8 !== 1'b0) begin
            errors++;
            $display("FAIL midframe_ready: got %b expected 0", ready8);
        end
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send8(8'h5A);
`ifdef UART_TX_PARITY_EN
        check_frame("after_rst_5a", 1'b0, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11);
`else
        check_frame("after_rst_5a", 1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_seven_two();
        data7  = 7'h41;
        valid7 = 1'b1;
        @(posedge clk);
        #1;
        valid7 = 1'b0;
        data7  = 7'h00;
`ifdef UART_TX_PARITY_EN
        check_frame("d7s2_41", 1'b1, 16'({2'b11, 1'b0, 7'h41, 1'b0}), 11);
`else
        check_frame("d7s2_41", 1'b1, 16'({2'b11, 7'h41, 1'b0}), 10);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        data8  = 8'h00;
        valid8 = 1'b0;
        data7  = 7'h00;
        valid7 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        test_seven_two();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

RS-232 UART transmitter, companion to the CDR/receiver path, clocked from the same 16× oversampling clock. It accepts parallel bytes through a valid/ready handshake and serialises them as start bit, data bits (LSB first), optional even parity bit and stop bit(s). Each bit lasts exactly 16 CLK_x16 cycles. TXD idles high.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..8
- STOP_BITS, 1, stop bits per frame; legal 1 or 2
- CLK_x16  input  1  16× bit-rate clock; the only clock
- RST  input  1  asynchronous, active-high reset
- TX_DATA  input  DATA_BITS  byte to send; sampled only on handshake
- TX_VALID  input  1  TX_DATA is valid
- TX_READY  output  1  transmitter can accept a byte
- TXD  output  1  serial line, registered, idle high
- BUSY  output  1  frame in progress (state ≠ IDLE)

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Handshake: TX_VALID && TX_READY at a CLK_x16 edge. TX_DATA is latched into the shift register on that edge. TX_VALID is ignored while TX_READY is low.
- TX_READY = (state == IDLE) && !RST. It is combinational from the state register.
- Tick counter: 4 bits, runs 0..15 within each bit. It is cleared on entry to each state and wraps 15→0 on each bit boundary.
- Bit counter: width $clog2(DATA_BITS) for data bits. A separate stop-bit count is used when STOP_BITS=2.
- IDLE → START on handshake: TXD <= 0, tick counter <= 0.
- START → DATA at tick 15: TXD <= shift[0].
- DATA: at each tick 15, shift right and send the next bit. After bit DATA_BITS-1 completes, go to PARITY (macro on) or STOP (macro off).
- PARITY → STOP at tick 15. TXD carries the parity bit during PARITY.
- STOP: TXD = 1 for 16×STOP_BITS cycles, then → IDLE (TXD stays 1).
- Reset values: TXD=1, state=IDLE, BUSY=0, counters=0, shift register=0. TX_READY=0 while RST is high.
- Reset mid-frame: TXD returns high immediately (asynchronously). The partial frame is abandoned. No resumption after release.

## Timing
- Handshake at edge N: TXD low from edge N through edge N+15. The first data bit appears at edge N+16.
- Frame length, measured from edge N to the return to IDLE: 16×(1+DATA_BITS+P+STOP_BITS), where P=1 if parity is enabled.
  - Default configuration: 160 cycles.
  - Parity enabled: 176 cycles.
- TX_READY falls at edge N and rises at edge N+frame length.
- Earliest next handshake is at edge N+frame length+1. With TX_VALID held high, consecutive frames therefore have period frame length+1. The last stop bit is stretched by one cycle, which is legal per RS-232.
- BUSY mirrors !TX_READY outside reset.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state exists.
  - An even parity bit (XOR of all DATA_BITS data bits) is sent after the MSB.
  - Frame length gains 16 cycles.
- UART_TX_PARITY_EN undefined:
  - No PARITY state or logic.
  - DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - OVERSAMPLE = 16 and TICK_W = 4 constants.
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}, shared with the receiver FSM.
- One sub-module, uart_bit_timer: the 4-bit tick counter with clear input and tick-15 (bit_done) output. It is reusable by the receiver.

## Test plan
- Reset: RST=1 → TXD=1, TX_READY=0, BUSY=0. Release RST → TX_READY=1 at the next edge, TXD stays 1.
- Single byte 8'hA5 (default params): TXD = 0, then 1,0,1,0,0,1,0,1, then 1. Each bit is 16 cycles. TX_READY is low for exactly 160 cycles.
- Back-to-back 8'h00 then 8'hFF with TX_VALID held high: second start bit begins at edge N+161. Data bits are all 0 then all 1. Stop bit between frames is 17 cycles.
- UART_TX_PARITY_EN, 8'h07: parity bit = 1 after the MSB. Frame is 176 cycles. With 8'h03, parity bit = 0.
- Reset asserted 50 cycles into a frame: TXD goes high with no clock edge. BUSY=0. After release, a new 8'h5A frame transmits correctly with no residue of the old data.
- DATA_BITS=7, STOP_BITS=2, 7'h41: 0, 1,0,0,0,0,0,1, then 1 for 32 cycles. Frame is 160 cycles.
